// File: rtl/game_pkg.sv
// Shared types and helpers for the multi-player game schedulers.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [3:0] DEFAULT_WIN_THRESHOLD = 4'b1000;

  // Index width for n players, never narrower than one bit.
  function automatic int unsigned player_w(input int unsigned n);
    return (n < 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/player_scheduler_if.sv
// Player-side bus of the turn scheduler: per-player inputs and muxed display outputs.
interface player_scheduler_if
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned STATUS_W    = 4,
  parameter int unsigned POS_W       = 4
);
  localparam int unsigned PLAYER_W = player_w(NUM_PLAYERS);

  logic                            start;
  logic [NUM_PLAYERS*STATUS_W-1:0] status_in;
  logic [NUM_PLAYERS*POS_W-1:0]    position_in;
  logic [NUM_PLAYERS-1:0]          enables;
  logic [PLAYER_W-1:0]             current_player;
  logic [STATUS_W-1:0]             status_code;
  logic [POS_W-1:0]                position;
  logic                            slot_start;
  logic                            win;
  logic [PLAYER_W-1:0]             winner;
  logic                            game_over;

  modport master (
    output start, status_in, position_in,
    input  enables, current_player, status_code, position,
           slot_start, win, winner, game_over
  );

  modport slave (
    input  start, status_in, position_in,
    output enables, current_player, status_code, position,
           slot_start, win, winner, game_over
  );

endinterface

// File: rtl/rr_next_enabled.sv
// Combinational circular priority search: first set bit of enables at or after start_idx.
module rr_next_enabled
  import game_pkg::*;
#(
  parameter  int unsigned NUM   = 4,
  localparam int unsigned IDX_W = player_w(NUM)
) (
  input  logic [NUM-1:0]   enables,
  input  logic [IDX_W-1:0] start_idx,
  output logic [IDX_W-1:0] next_idx_c,
  output logic             found_c
);

  logic [31:0] probe;

  // Walk NUM positions from start_idx, wrapping past NUM-1 back to 0.
  always_comb begin
    next_idx_c = '0;
    found_c    = 1'b0;
    probe      = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      probe = (32'(start_idx) + 32'(i)) % 32'(NUM);
      if (!found_c && enables[probe[IDX_W-1:0]]) begin
        found_c    = 1'b1;
        next_idx_c = probe[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/player_scheduler.sv
// Time-slice scheduler rotating a turn slot across players, retiring winners and ending the game.
module player_scheduler
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 4,
  parameter int unsigned TICK_DIV      = 10000,
  parameter int unsigned STATUS_W      = 4,
  parameter int unsigned POS_W         = 4,
  parameter int unsigned WIN_THRESHOLD = 32'(DEFAULT_WIN_THRESHOLD),
  parameter int unsigned STOP_AT       = 1
) (
  input logic               clk,
  input logic               rst,
  player_scheduler_if.slave bus
);

  localparam int unsigned PLAYER_W = player_w(NUM_PLAYERS);
  localparam int unsigned CNT_W    = (TICK_DIV < 2) ? 1 : int'($clog2(TICK_DIV));
  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);

  state_t                 state;
  logic [CNT_W-1:0]       tick_cnt;
  logic [NUM_PLAYERS-1:0] enables_q;
  logic [PLAYER_W-1:0]    cur_q;
  logic [PLAYER_W-1:0]    winner_q;
  logic [STATUS_W-1:0]    status_q;
  logic [POS_W-1:0]       pos_q;
  logic                   slot_start_q;
  logic                   win_q;
  logic                   game_over_q;

  logic                   slot_end_c;
  logic                   win_c;
  logic                   stop_c;
  logic [NUM_PLAYERS-1:0] enables_upd_c;
  logic [PLAYER_W-1:0]    search_start_c;
  logic [PLAYER_W-1:0]    next_player_c;
  logic                   next_found_c;

  function automatic int unsigned count_ones(input logic [NUM_PLAYERS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) n += 32'(v[i]);
    return n;
  endfunction

  // Slot-end evaluation: retire the current player on a win, then decide advance vs. game end.
  always_comb begin
    slot_end_c     = (state == PLAY) && (tick_cnt == CNT_LAST);
    win_c          = slot_end_c && enables_q[cur_q] && (32'(status_q) > WIN_THRESHOLD);
    enables_upd_c  = enables_q;
    if (win_c) enables_upd_c[cur_q] = 1'b0;
    search_start_c = (cur_q == LAST_PLAYER) ? '0 : PLAYER_W'(cur_q + 1'b1);
    stop_c         = count_ones(enables_upd_c) <= STOP_AT;
  end

  rr_next_enabled #(
    .NUM (NUM_PLAYERS)
  ) u_next (
    .enables    (enables_upd_c),
    .start_idx  (search_start_c),
    .next_idx_c (next_player_c),
    .found_c    (next_found_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      enables_q    <= '1;
      cur_q        <= '0;
      winner_q     <= '0;
      status_q     <= '0;
      pos_q        <= '0;
      slot_start_q <= 1'b0;
      win_q        <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      win_q        <= 1'b0;
      slot_start_q <= 1'b0;

      // Display mux follows the slot owner whenever a game is in progress or finished.
      if (state != IDLE) begin
        status_q <= bus.status_in[32'(cur_q)*STATUS_W +: STATUS_W];
        pos_q    <= bus.position_in[32'(cur_q)*POS_W +: POS_W];
      end

      // A start request overrides whatever the slot end would have done.
      if (bus.start) begin
        state        <= PLAY;
        enables_q    <= '1;
        tick_cnt     <= '0;
        cur_q        <= '0;
        game_over_q  <= 1'b0;
        slot_start_q <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          PLAY: begin
            if (slot_end_c) begin
              tick_cnt  <= '0;
              enables_q <= enables_upd_c;
              if (win_c) begin
                win_q    <= 1'b1;
                winner_q <= cur_q;
              end
              if (stop_c) begin
                state       <= OVER;
                game_over_q <= 1'b1;
              end else begin
                slot_start_q <= 1'b1;
                if (next_found_c) cur_q <= next_player_c;
              end
            end else begin
              tick_cnt <= CNT_W'(tick_cnt + 1'b1);
            end
          end
          OVER: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.enables        = enables_q;
  assign bus.current_player = cur_q;
  assign bus.status_code    = status_q;
  assign bus.position       = pos_q;
  assign bus.slot_start     = slot_start_q;
  assign bus.win            = win_q;
  assign bus.winner         = winner_q;
  assign bus.game_over      = game_over_q;

endmodule

// File: tb/tb_player_scheduler.sv
// Scoreboard bench for player_scheduler: 4-player/TICK_DIV=4 instance plus a 3-player/TICK_DIV=1 instance.
module tb_player_scheduler;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  player_scheduler_if #(.NUM_PLAYERS(4), .STATUS_W(4), .POS_W(4)) bus4 ();
  player_scheduler_if #(.NUM_PLAYERS(3), .STATUS_W(4), .POS_W(4)) bus3 ();

  player_scheduler #(
    .NUM_PLAYERS(4), .TICK_DIV(4), .STATUS_W(4), .POS_W(4),
    .WIN_THRESHOLD(8), .STOP_AT(1)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  player_scheduler #(
    .NUM_PLAYERS(3), .TICK_DIV(1), .STATUS_W(4), .POS_W(4),
    .WIN_THRESHOLD(8), .STOP_AT(1)
  ) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  typedef struct packed {
    logic [1:0] cur;
    logic [3:0] en;
  } slot_t;

  slot_t      slot_q[$];
  slot_t      win_q[$];
  logic [1:0] slot3_q[$];
  slot_t      e4;
  slot_t      w4;
  logic [1:0] e3;
  logic       win_prev = 1'b0;
  bit         mon3_en  = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic slot_t rec(input logic [1:0] cur, input logic [3:0] en);
    slot_t r;
    r.cur = cur;
    r.en  = en;
    return r;
  endfunction

  // Slot/win monitor for the 4-player instance.
  always @(negedge clk) begin
    if (rst) begin
      if (bus4.slot_start) begin
        if (slot_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL slot4_unexpected: cur=%0d en=%b", bus4.current_player, bus4.enables);
        end else begin
          e4 = slot_q.pop_front();
          check("slot4_cur", 32'(bus4.current_player), 32'(e4.cur));
          check("slot4_en", 32'(bus4.enables), 32'(e4.en));
          check("slot4_game_over", 32'(bus4.game_over), 32'(0));
        end
      end
      if (bus4.win) begin
        check("win4_one_cycle", 32'(win_prev), 32'(0));
        if (win_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL win4_unexpected: winner=%0d en=%b", bus4.winner, bus4.enables);
        end else begin
          w4 = win_q.pop_front();
          check("win4_winner", 32'(bus4.winner), 32'(w4.cur));
          check("win4_en", 32'(bus4.enables), 32'(w4.en));
        end
      end
      win_prev = bus4.win;
    end else begin
      win_prev = 1'b0;
    end
  end

  // Slot monitor for the 3-player instance.
  always @(negedge clk) begin
    if (rst3 && mon3_en && bus3.slot_start) begin
      if (slot3_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL slot3_unexpected: cur=%0d", bus3.current_player);
      end else begin
        e3 = slot3_q.pop_front();
        check("slot3_cur", 32'(bus3.current_player), 32'(e3));
        check("slot3_en", 32'(bus3.enables), 32'(3'b111));
      end
    end
    if (rst3 && bus3.win) begin
      checks++;
      failures++;
      $display("FAIL win3_unexpected: winner=%0d", bus3.winner);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start4();
    @(negedge clk);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic drain4(input string name, input int budget);
    int n;
    n = 0;
    while ((slot_q.size() != 0 || win_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(slot_q.size() + win_q.size()), 32'(0));
    slot_q.delete();
    win_q.delete();
  endtask

  task automatic check_reset4(input string tag);
    check({tag, "_enables"}, 32'(bus4.enables), 32'(4'b1111));
    check({tag, "_cur"}, 32'(bus4.current_player), 32'(0));
    check({tag, "_winner"}, 32'(bus4.winner), 32'(0));
    check({tag, "_status"}, 32'(bus4.status_code), 32'(0));
    check({tag, "_position"}, 32'(bus4.position), 32'(0));
    check({tag, "_win"}, 32'(bus4.win), 32'(0));
    check({tag, "_slot_start"}, 32'(bus4.slot_start), 32'(0));
    check({tag, "_game_over"}, 32'(bus4.game_over), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst  = 1'b0;
    rst3 = 1'b0;
    bus4.start       = 1'b0;
    bus4.status_in   = 16'h0000;
    bus4.position_in = 16'hA765;
    bus3.start       = 1'b0;
    bus3.status_in   = 12'h000;
    bus3.position_in = 12'h000;

    tick(3);
    check_reset4("reset");
    check("reset3_enables", 32'(bus3.enables), 32'(3'b111));
    rst  = 1'b1;
    rst3 = 1'b1;
    tick(4);
    check("idle_slot_start", 32'(bus4.slot_start), 32'(0));
    check("idle_cur", 32'(bus4.current_player), 32'(0));

    // 3 players, one-cycle slots: slot_start stays high and wraps 2 -> 0.
    foreach (slot3_q[i]) slot3_q.delete();
    slot3_q.push_back(2'd0); slot3_q.push_back(2'd1); slot3_q.push_back(2'd2);
    slot3_q.push_back(2'd0); slot3_q.push_back(2'd1); slot3_q.push_back(2'd2);
    slot3_q.push_back(2'd0);
    mon3_en = 1'b1;
    @(negedge clk);
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    n = 0;
    while (slot3_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    mon3_en = 1'b0;
    check("t3p_drain", 32'(slot3_q.size()), 32'(0));
    slot3_q.delete();
    rst3 = 1'b0;

    // Plain rotation, no wins.
    slot_q.push_back(rec(2'd0, 4'hF)); slot_q.push_back(rec(2'd1, 4'hF));
    slot_q.push_back(rec(2'd2, 4'hF)); slot_q.push_back(rec(2'd3, 4'hF));
    slot_q.push_back(rec(2'd0, 4'hF));
    pulse_start4();
    drain4("t1_drain", 40);
    @(negedge clk);
    check("t1_position_p0", 32'(bus4.position), 32'(4'h5));

    // Player 1 wins and is skipped afterwards.
    bus4.status_in = 16'h0090;
    slot_q.push_back(rec(2'd0, 4'hF)); slot_q.push_back(rec(2'd1, 4'hF));
    slot_q.push_back(rec(2'd2, 4'hD)); slot_q.push_back(rec(2'd3, 4'hD));
    slot_q.push_back(rec(2'd0, 4'hD)); slot_q.push_back(rec(2'd2, 4'hD));
    win_q.push_back(rec(2'd1, 4'hD));
    pulse_start4();
    drain4("t2_drain", 60);
    check("t2_winner_held", 32'(bus4.winner), 32'(1));

    // Status equal to the threshold is not a win.
    bus4.status_in = 16'h8000;
    slot_q.push_back(rec(2'd0, 4'hF)); slot_q.push_back(rec(2'd1, 4'hF));
    slot_q.push_back(rec(2'd2, 4'hF)); slot_q.push_back(rec(2'd3, 4'hF));
    slot_q.push_back(rec(2'd0, 4'hF)); slot_q.push_back(rec(2'd1, 4'hF));
    pulse_start4();
    drain4("t3_drain", 60);
    check("t3_enables", 32'(bus4.enables), 32'(4'hF));
    check("t3_winner_held", 32'(bus4.winner), 32'(1));

    // Three wins leave one player: game over.
    bus4.status_in = 16'h9909;
    slot_q.push_back(rec(2'd0, 4'hF)); slot_q.push_back(rec(2'd1, 4'hE));
    slot_q.push_back(rec(2'd2, 4'hE)); slot_q.push_back(rec(2'd3, 4'hA));
    win_q.push_back(rec(2'd0, 4'hE)); win_q.push_back(rec(2'd2, 4'hA));
    win_q.push_back(rec(2'd3, 4'h2));
    pulse_start4();
    drain4("t4_drain", 60);
    tick(2);
    check("t4_game_over", 32'(bus4.game_over), 32'(1));
    check("t4_enables", 32'(bus4.enables), 32'(4'b0010));
    check("t4_cur_hold", 32'(bus4.current_player), 32'(3));
    check("t4_winner", 32'(bus4.winner), 32'(3));
    check("t4_status_mux", 32'(bus4.status_code), 32'(9));
    check("t4_position_mux", 32'(bus4.position), 32'(4'hA));
    tick(12);
    check("t4_game_over_held", 32'(bus4.game_over), 32'(1));
    check("t4_enables_held", 32'(bus4.enables), 32'(4'b0010));

    // Restart from OVER, then start lands on the slot end of a winning player 2.
    bus4.status_in = 16'h0900;
    slot_q.push_back(rec(2'd0, 4'hF)); slot_q.push_back(rec(2'd1, 4'hF));
    slot_q.push_back(rec(2'd2, 4'hF));
    pulse_start4();
    check("t5_game_over_cleared", 32'(bus4.game_over), 32'(0));
    n = 0;
    @(negedge clk);
    while (!(bus4.slot_start && bus4.current_player == 2'd2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_p2", 32'(n < 40), 32'(1));
    slot_q.push_back(rec(2'd0, 4'hF)); slot_q.push_back(rec(2'd1, 4'hF));
    tick(3);
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    check("t5_no_win", 32'(bus4.win), 32'(0));
    check("t5_cur", 32'(bus4.current_player), 32'(0));
    check("t5_enables", 32'(bus4.enables), 32'(4'hF));
    drain4("t5_drain", 40);

    // Reset mid-slot while player 2 is about to win.
    slot_q.push_back(rec(2'd2, 4'hF));
    drain4("t6_reach_p2", 40);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset4("t6_async");
    tick(6);
    check("t6_held_win", 32'(bus4.win), 32'(0));
    check("t6_held_enables", 32'(bus4.enables), 32'(4'hF));
    rst = 1'b1;
    tick(10);
    check("t6_idle_cur", 32'(bus4.current_player), 32'(0));
    check("t6_idle_game_over", 32'(bus4.game_over), 32'(0));
    check("t6_idle_status", 32'(bus4.status_code), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
